// File: rtl/delay_line_multi.sv
// -----------------------------------------------------------------------------
// delay_line_multi
//   Runtime-programmable multi-lane delay line. All lanes share one circular
//   buffer and one write/read pointer, so every lane sees the same delay. The
//   delay (1..pMaxDelay) is loaded at run time. A fill counter tracks how many
//   samples have entered since the last flush, and val_valid marks when val_out
//   carries a real sample rather than flushed or primed-but-unwritten storage.
//
// Ports
//   clk        in   rising-edge clock
//   reset      in   asynchronous, active-high reset
//   enable     in   advance the line by one sample on this edge
//   clear      in   synchronous flush (pointer, fill, outputs zeroed)
//   load       in   synchronous: take clamped delay_in, then flush
//   delay_in   in   requested delay
//   val_in     in   lane i at [i*pDataLength +: pDataLength]
//   val_out    out  delayed lanes, registered
//   val_valid  out  val_out holds real (non-flush) data
//   delay_out  out  delay currently in effect
// -----------------------------------------------------------------------------
module delay_line_multi #(
  parameter int unsigned pChannels     = 4,
  parameter int unsigned pDataLength   = 16,
  parameter int unsigned pMaxDelay     = 16,
  parameter int unsigned pDefaultDelay = 8,
  parameter int unsigned pDelayWidth   = 5
) (
  input  logic                               clk,
  input  logic                               reset,
  input  logic                               enable,
  input  logic                               clear,
  input  logic                               load,
  input  logic [pDelayWidth-1:0]             delay_in,
  input  logic [pChannels*pDataLength-1:0]   val_in,
  output logic [pChannels*pDataLength-1:0]   val_out,
  output logic                               val_valid,
  output logic [pDelayWidth-1:0]             delay_out
);

  localparam int unsigned cWidth = pChannels * pDataLength;
  localparam int unsigned cDepth = pMaxDelay - 1;
  localparam int unsigned cPtrW  = (cDepth > 1) ? $clog2(cDepth) : 1;

  localparam logic [pDelayWidth-1:0] cMaxDelay = pDelayWidth'(pMaxDelay);
  localparam logic [pDelayWidth-1:0] cDefDelay = pDelayWidth'(pDefaultDelay);
  localparam logic [pDelayWidth-1:0] cOne      = pDelayWidth'(1);
  localparam logic [pDelayWidth-1:0] cTwo      = pDelayWidth'(2);

  // Shared sample storage; contents are not reset, val_valid gates them.
  logic [cWidth-1:0]      r_mem [cDepth];

  logic [cPtrW-1:0]       r_ptr;
  logic [pDelayWidth-1:0] r_fill;
  logic [pDelayWidth-1:0] r_delay;
  logic [cWidth-1:0]      r_val_out;
  logic                   r_valid;

  logic [pDelayWidth-1:0] w_delay_clamped;
  logic                   w_bypass;
  logic [pDelayWidth-1:0] w_wrap_idx;
  logic                   w_ptr_last;
  logic [cPtrW-1:0]       w_ptr_next;
  logic [pDelayWidth-1:0] w_fill_next;
  logic                   w_advance;
  logic                   w_write;
  logic [cWidth-1:0]      w_mem_rd;

  // Requested delay limited to the supported range 1..pMaxDelay.
  always_comb begin
    w_delay_clamped = delay_in;
    if (delay_in == '0) begin
      w_delay_clamped = cOne;
    end else if (delay_in > cMaxDelay) begin
      w_delay_clamped = cMaxDelay;
    end
  end

  // D=1 is a plain register; the buffer is only used for D>=2, where D-1
  // entries plus the output register give a latency of D enabled edges.
  assign w_bypass   = (r_delay < cTwo);
  assign w_wrap_idx = r_delay - cTwo;
  assign w_ptr_last = (pDelayWidth'(r_ptr) == w_wrap_idx);
  assign w_ptr_next = w_ptr_last ? '0 : r_ptr + cPtrW'(1);

  assign w_fill_next = (r_fill == r_delay) ? r_fill : r_fill + cOne;

  // load and clear both flush the line and suppress the sample of that edge.
  assign w_advance = enable && !load && !clear;
  assign w_write   = w_advance && !w_bypass && !reset;

  assign w_mem_rd = r_mem[r_ptr];

  always_ff @(posedge clk) begin
    if (w_write) begin
      r_mem[r_ptr] <= val_in;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_ptr     <= '0;
      r_fill    <= '0;
      r_delay   <= cDefDelay;
      r_val_out <= '0;
      r_valid   <= 1'b0;
    end else if (load) begin
      r_delay   <= w_delay_clamped;
      r_ptr     <= '0;
      r_fill    <= '0;
      r_val_out <= '0;
      r_valid   <= 1'b0;
    end else if (clear) begin
      r_ptr     <= '0;
      r_fill    <= '0;
      r_val_out <= '0;
      r_valid   <= 1'b0;
    end else if (enable) begin
      r_fill  <= w_fill_next;
      r_valid <= (w_fill_next == r_delay);
      if (w_bypass) begin
        r_val_out <= val_in;
      end else begin
        r_val_out <= w_mem_rd;
        r_ptr     <= w_ptr_next;
      end
    end
  end

  assign val_out   = r_val_out;
  assign val_valid = r_valid;
  assign delay_out = r_delay;

endmodule

// File: tb/tb_delay_line_multi.sv
module tb_delay_line_multi;

  localparam int unsigned CH = 4;
  localparam int unsigned DL = 16;
  localparam int unsigned DW = 5;
  localparam int unsigned VW = CH * DL;

  logic          clk = 1'b0;
  logic          reset;
  logic          enable;
  logic          clear;
  logic          load;
  logic [DW-1:0] delay_in;
  logic [VW-1:0] val_in;
  logic [VW-1:0] val_out;
  logic          val_valid;
  logic [DW-1:0] delay_out;

  delay_line_multi #(
    .pChannels(CH), .pDataLength(DL), .pMaxDelay(16),
    .pDefaultDelay(8), .pDelayWidth(DW)
  ) dut (
    .clk(clk), .reset(reset), .enable(enable), .clear(clear), .load(load),
    .delay_in(delay_in), .val_in(val_in), .val_out(val_out),
    .val_valid(val_valid), .delay_out(delay_out)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic          v;
    logic [VW-1:0] d;
    logic [DW-1:0] dl;
    bit            chk_data;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  // Reference model: a plain FIFO of samples since the last flush.
  logic [VW-1:0] m_hist[$];
  int            m_delay;
  logic [VW-1:0] m_out;
  logic          m_valid;
  bit            m_known;

  function automatic logic [VW-1:0] mkvec(input int base);
    logic [VW-1:0] v;
    for (int i = 0; i < CH; i++) v[i*DL +: DL] = 16'(base + i * 16'h1000);
    return v;
  endfunction

  task automatic model_flush();
    m_hist.delete();
    m_out   = '0;
    m_valid = 1'b0;
    m_known = 1'b1;
  endtask

  task automatic step(input bit en, input bit ld, input bit clr,
                      input int din, input int base);
    exp_t e;
    @(negedge clk);
    enable   = en;
    load     = ld;
    clear    = clr;
    delay_in = DW'(din);
    val_in   = mkvec(base);
    if (ld) begin
      m_delay = (din == 0) ? 1 : (din > 16) ? 16 : din;
      model_flush();
    end else if (clr) begin
      model_flush();
    end else if (en) begin
      m_hist.push_back(mkvec(base));
      if (m_hist.size() > m_delay) void'(m_hist.pop_front());
      if (m_hist.size() == m_delay) begin
        m_out   = m_hist[0];
        m_valid = 1'b1;
      end else begin
        m_known = 1'b0;
      end
    end
    e.v        = m_valid;
    e.d        = m_out;
    e.dl       = DW'(m_delay);
    e.chk_data = m_valid || m_known;
    sb.push_back(e);
  endtask

  // Monitor: one expected entry per stepped edge.
  exp_t me;
  always @(posedge clk) begin
    #1;
    if (sb.size() > 0) begin
      me = sb.pop_front();
      checks++;
      if (val_valid !== me.v) begin
        errors++;
        $display("FAIL valid @%0t: got %b expected %b", $time, val_valid, me.v);
      end
      checks++;
      if (delay_out !== me.dl) begin
        errors++;
        $display("FAIL delay_out @%0t: got %0d expected %0d", $time, delay_out, me.dl);
      end
      if (me.chk_data) begin
        checks++;
        if (val_out !== me.d) begin
          errors++;
          $display("FAIL val_out @%0t: got %h expected %h", $time, val_out, me.d);
        end
      end
    end
  end

  task automatic check_rst(input string name);
    checks++;
    if (val_out !== '0) begin
      errors++; $display("FAIL %s val_out: got %h expected 0", name, val_out);
    end
    checks++;
    if (val_valid !== 1'b0) begin
      errors++; $display("FAIL %s valid: got %b expected 0", name, val_valid);
    end
    checks++;
    if (delay_out !== DW'(8)) begin
      errors++; $display("FAIL %s delay_out: got %0d expected 8", name, delay_out);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    reset = 1'b1; enable = 1'b0; clear = 1'b0; load = 1'b0;
    delay_in = '0; val_in = '0;
    m_delay = 8; model_flush();
    repeat (2) @(negedge clk);
    #1 check_rst("reset");
    @(negedge clk); reset = 1'b0;

    // Default delay 8, continuous stream
    for (int k = 1; k <= 12; k++) step(1, 0, 0, 0, k);

    // Delay 1: plain register
    step(1, 1, 0, 1, 0);
    for (int k = 10; k <= 12; k++) step(1, 0, 0, 0, k);

    // Maximum delay, pointer wraps at 14
    step(0, 1, 0, 16, 0);
    for (int k = 1; k <= 20; k++) step(1, 0, 0, 0, 100 + k);
    step(1, 1, 0, 0, 0);   // clamps to 1
    step(0, 1, 0, 20, 0);  // clamps to 16

    // Delay 4, enable toggling
    step(0, 1, 0, 4, 0);
    for (int k = 1; k <= 12; k++) step(k % 2 == 1, 0, 0, 0, 200 + k);

    // Mid-stream clear with enable high
    for (int k = 1; k <= 6; k++) step(1, 0, 0, 0, 300 + k);
    step(1, 0, 1, 0, 399);
    for (int k = 1; k <= 6; k++) step(1, 0, 0, 0, 400 + k);

    // Asynchronous reset between edges
    @(negedge clk);
    enable = 1'b0; load = 1'b0; clear = 1'b0;
    #2 reset = 1'b1;
    #1 check_rst("async_reset");
    m_delay = 8; model_flush();
    repeat (2) @(negedge clk);
    reset = 1'b0;

    // load + clear together: new delay wins, line flushed
    for (int k = 1; k <= 3; k++) step(1, 0, 0, 0, 500 + k);
    step(1, 1, 1, 3, 599);
    for (int k = 1; k <= 6; k++) step(1, 0, 0, 0, 600 + k);

    step(0, 0, 0, 0, 0);
    repeat (3) @(negedge clk);
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: got %0d entries expected 0", sb.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
